stopwatch_dp: RTL and testbench
===============================

// Module: stopwatch_dp
// PURPOSE
//  Stopwatch datapath, directly downstream of the stopwatch control FSM.
//  Consumes the FSM's level outputs (run, clear) and maintains a
//  hour:min:sec:centisecond time count driven by an internal prescaler.
//  Feeds the display/FND formatting stage with binary digit-group values.
// PARAMETERS
//  CLK_FREQ  100_000_000  input clock frequency in Hz
//  TICK_HZ   100          centisecond tick rate in Hz
//  Derived:  DIV = CLK_FREQ/TICK_HZ (integer, >= 2)
//  Derived:  prescaler width = $clog2(DIV)
// PORTS
//  clk      in   1  system clock, all logic on posedge
//  reset    in   1  asynchronous, active-low reset (0 = reset)
//  i_run    in   1  level from control FSM: 1 = count, 0 = hold
//  i_clear  in   1  level from control FSM: 1 = zero all counters
//  o_msec   out  7  centiseconds, 0..99
//  o_sec    out  6  seconds, 0..59
//  o_min    out  6  minutes, 0..59
//  o_hour   out  5  hours, 0..23
//  o_tick   out  1  one-cycle pulse, high in the cycle o_msec shows a new count
// BEHAVIOUR
//  Reset (reset=0, async): prescaler, o_msec, o_sec, o_min, o_hour,
//    o_tick all 0. Reset released mid-count restarts from 00:00:00:00.
//  Priority per clock edge: i_clear > i_run > hold.
//  Clear (i_clear=1): sync zero of prescaler and all time outputs.
//    o_tick=0. Holds zero for as long as i_clear stays high,
//    regardless of i_run.
//  Run (i_run=1, i_clear=0):
//    - prescaler increments by 1 each cycle.
//    - when prescaler==DIV-1: prescaler->0 and a tick fires.
//    - tick: o_msec +1 at that edge, so first increment DIV cycles after
//      run rises from a zeroed prescaler.
//  Hold (i_run=0, i_clear=0): prescaler and time outputs frozen.
//    Prescaler phase is preserved, so pause/resume loses no partial tick.
//  Carry chain, all in the same edge as the tick (no ripple latency):
//    - msec 99->0 carries to sec.
//    - sec 59->0 carries to min.
//    - min 59->0 carries to hour.
//    - hour 23->0 wraps; 23:59:59:99 + tick = 00:00:00:00.
//  o_tick: registered. High exactly 1 cycle, coincident with the first
//    cycle the updated o_msec is visible. Never high during clear/reset.
//  Outputs are registered directly; no combinational path from inputs.
//  Counters never exceed their maxima. Out-of-range values are unreachable.
// TESTING  (bench uses CLK_FREQ=1000, TICK_HZ=100 -> DIV=10)
//  1 Reset: hold reset=0 with i_run=1 -> all outputs 0.
//    Release, run 10 cycles -> o_msec=1, o_tick pulses once.
//  2 Run 1000 cycles from zero -> o_msec=0, o_sec=1.
//    100 o_tick pulses seen, spaced exactly 10 cycles apart.
//  3 Pause: run 25 cycles (o_msec=2, prescaler=5), i_run=0 for 40 cycles
//    -> outputs frozen. Resume -> o_msec=3 after exactly 5 more cycles.
//  4 Clear priority: at o_msec=7, raise i_clear with i_run=1 for 20 cycles
//    -> all 0, no o_tick. Drop both, then run 10 cycles -> o_msec=1.
//  5 Full wrap: run from zero for 8_640_000 ticks
//    -> passes 23:59:59:99, then next tick -> 00:00:00:00.
//    Check 00:00:59:99 -> 00:01:00:00 and 00:59:59:99 -> 01:00:00:00.
//  6 Async reset mid-count: assert reset=0 between clock edges at
//    12:34:56:78 -> outputs 0 immediately, before the next posedge.

Source files
------------

// File: rtl/stopwatch_dp_if.sv
// Control/datapath bus for the stopwatch datapath: run/clear levels in,
// binary time digit-groups and the centisecond tick out.
interface stopwatch_dp_if;
  logic       i_run;
  logic       i_clear;
  logic [6:0] o_msec;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic       o_tick;

  modport master (output i_run, i_clear, input o_msec, o_sec, o_min, o_hour, o_tick);
  modport slave  (input i_run, i_clear, output o_msec, o_sec, o_min, o_hour, o_tick);
endinterface

// File: rtl/stopwatch_dp.sv
// Stopwatch datapath: prescaled centisecond counter with a same-edge
// carry chain into sec/min/hour.
module stopwatch_dp #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned TICK_HZ  = 100
) (
  input  logic                 clk,
  input  logic                 reset,
  stopwatch_dp_if.slave        bus
);

  localparam int unsigned DIV = CLK_FREQ / TICK_HZ;
  localparam int unsigned PW  = $clog2(DIV);

  logic [PW-1:0] presc;
  logic          presc_last_c;
  logic          msec_wrap_c;
  logic          sec_wrap_c;
  logic          min_wrap_c;
  logic          hour_wrap_c;

  always_comb begin
    presc_last_c = (presc == PW'(DIV - 1));
    msec_wrap_c  = (bus.o_msec == 7'd99);
    sec_wrap_c   = (bus.o_sec  == 6'd59);
    min_wrap_c   = (bus.o_min  == 6'd59);
    hour_wrap_c  = (bus.o_hour == 5'd23);
  end

  // Clear beats run; hold leaves the prescaler phase untouched so a
  // pause never discards a partial tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc      <= '0;
      bus.o_msec <= '0;
      bus.o_sec  <= '0;
      bus.o_min  <= '0;
      bus.o_hour <= '0;
      bus.o_tick <= 1'b0;
    end else if (bus.i_clear) begin
      presc      <= '0;
      bus.o_msec <= '0;
      bus.o_sec  <= '0;
      bus.o_min  <= '0;
      bus.o_hour <= '0;
      bus.o_tick <= 1'b0;
    end else begin
      bus.o_tick <= 1'b0;
      if (bus.i_run) begin
        if (presc_last_c) begin
          presc      <= '0;
          bus.o_tick <= 1'b1;
          // Whole carry chain resolves in the tick edge.
          if (msec_wrap_c) begin
            bus.o_msec <= '0;
            if (sec_wrap_c) begin
              bus.o_sec <= '0;
              if (min_wrap_c) begin
                bus.o_min  <= '0;
                bus.o_hour <= hour_wrap_c ? 5'd0 : bus.o_hour + 5'd1;
              end else begin
                bus.o_min <= bus.o_min + 6'd1;
              end
            end else begin
              bus.o_sec <= bus.o_sec + 6'd1;
            end
          end else begin
            bus.o_msec <= bus.o_msec + 7'd1;
          end
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_dp.sv
// Self-checking bench for stopwatch_dp: directed scenarios plus random
// run/clear/reset traffic against a total-centisecond reference model.
module tb_stopwatch_dp;

  localparam int unsigned DIV = 10;
  localparam int unsigned DAY = 24 * 60 * 60 * 100;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  stopwatch_dp_if sw_if ();

  stopwatch_dp #(.CLK_FREQ(1000), .TICK_HZ(100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sw_if)
  );

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;
  int unsigned m_t   = 0;   // elapsed centiseconds since zero
  int unsigned m_ph  = 0;   // clocks accumulated toward the next tick
  bit          m_tick = 1'b0;
  int unsigned ticks_seen = 0;
  int unsigned cyc = 0;
  int unsigned last_tick = 0;

  task automatic chk(input string tag, input logic [31:0] got, input int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_cs"},   32'(sw_if.o_msec), m_t % 100);
    chk({tag, "_sec"},  32'(sw_if.o_sec),  (m_t / 100) % 60);
    chk({tag, "_min"},  32'(sw_if.o_min),  (m_t / 6000) % 60);
    chk({tag, "_hour"}, 32'(sw_if.o_hour), (m_t / 360000) % 24);
    chk({tag, "_tick"}, 32'(sw_if.o_tick), 32'(m_tick));
  endtask

  task automatic drive(input bit run, input bit clear);
    sw_if.i_run   = run;
    sw_if.i_clear = clear;
  endtask

  // One clock: advance the model on the edge, sample 1 time unit later.
  task automatic cycle(input string tag);
    @(posedge clk);
    if (!reset || sw_if.i_clear) begin
      m_t = 0; m_ph = 0; m_tick = 1'b0;
    end else if (sw_if.i_run) begin
      m_ph++;
      m_tick = (m_ph == DIV);
      if (m_tick) begin
        m_ph = 0;
        m_t  = (m_t + 1) % DAY;
      end
    end else begin
      m_tick = 1'b0;
    end
    #1;
    cyc++;
    if (sw_if.o_tick === 1'b1) ticks_seen++;
    check_all(tag);
  endtask

  task automatic run_n(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  // Deposit a time value into the counters without touching the prescaler.
  task automatic preload(input int unsigned h, input int unsigned m,
                         input int unsigned s, input int unsigned cs);
    force sw_if.o_hour = 5'(h);
    force sw_if.o_min  = 6'(m);
    force sw_if.o_sec  = 6'(s);
    force sw_if.o_msec = 7'(cs);
    #1;
    release sw_if.o_hour;
    release sw_if.o_min;
    release sw_if.o_sec;
    release sw_if.o_msec;
    m_t = ((h * 60 + m) * 60 + s) * 100 + cs;
  endtask

  initial begin
    drive(1'b1, 1'b0);
    reset = 1'b1;
    #1 reset = 1'b0;

    // Reset held with run high keeps everything at zero.
    #2;
    check_all("t1_async");
    run_n(3, "t1_rst");
    reset = 1'b1;
    ticks_seen = 0;
    run_n(DIV, "t1_run");
    chk("t1_ticks", ticks_seen, 1);
    chk("t1_msec", 32'(sw_if.o_msec), 1);

    // 1000 clocks from zero: one second, ticks every DIV clocks.
    drive(1'b0, 1'b1);
    cycle("t2_clr");
    drive(1'b1, 1'b0);
    ticks_seen = 0;
    last_tick  = cyc;
    for (int i = 0; i < 1000; i++) begin
      cycle("t2_run");
      if (sw_if.o_tick === 1'b1) begin
        chk("t2_gap", cyc - last_tick, DIV);
        last_tick = cyc;
      end
    end
    chk("t2_ticks", ticks_seen, 100);
    chk("t2_sec", 32'(sw_if.o_sec), 1);
    chk("t2_msec", 32'(sw_if.o_msec), 0);

    // Pause mid-tick and resume without losing prescaler phase.
    drive(1'b0, 1'b1);
    cycle("t3_clr");
    drive(1'b1, 1'b0);
    run_n(25, "t3_run");
    chk("t3_msec_a", 32'(sw_if.o_msec), 2);
    drive(1'b0, 1'b0);
    run_n(40, "t3_hold");
    chk("t3_msec_hold", 32'(sw_if.o_msec), 2);
    drive(1'b1, 1'b0);
    run_n(4, "t3_res");
    chk("t3_msec_4", 32'(sw_if.o_msec), 2);
    cycle("t3_res5");
    chk("t3_msec_5", 32'(sw_if.o_msec), 3);
    chk("t3_tick_5", 32'(sw_if.o_tick), 1);

    // Clear overrides run and suppresses ticks.
    drive(1'b0, 1'b1);
    cycle("t4_clr0");
    drive(1'b1, 1'b0);
    run_n(70, "t4_run");
    chk("t4_msec7", 32'(sw_if.o_msec), 7);
    drive(1'b1, 1'b1);
    ticks_seen = 0;
    run_n(20, "t4_clr");
    chk("t4_noticks", ticks_seen, 0);
    drive(1'b0, 1'b0);
    cycle("t4_idle");
    drive(1'b1, 1'b0);
    run_n(DIV, "t4_rerun");
    chk("t4_msec1", 32'(sw_if.o_msec), 1);

    // Carry boundaries and the daily wrap.
    drive(1'b0, 1'b1);
    cycle("t5_clr");
    drive(1'b0, 1'b0);
    preload(0, 0, 59, 99);
    drive(1'b1, 1'b0);
    run_n(DIV, "t5_min");
    chk("t5_min_carry", 32'(sw_if.o_min), 1);
    drive(1'b0, 1'b0);
    preload(0, 59, 59, 99);
    drive(1'b1, 1'b0);
    run_n(DIV, "t5_hour");
    chk("t5_hour_carry", 32'(sw_if.o_hour), 1);
    drive(1'b0, 1'b0);
    preload(23, 59, 59, 98);
    drive(1'b1, 1'b0);
    run_n(DIV, "t5_last");
    chk("t5_last_cs", 32'(sw_if.o_msec), 99);
    run_n(DIV, "t5_wrap");
    chk("t5_wrap_hour", 32'(sw_if.o_hour), 0);

    // Async reset between edges clears outputs before the next posedge.
    drive(1'b0, 1'b0);
    preload(12, 34, 56, 78);
    drive(1'b1, 1'b0);
    run_n(3, "t6_run");
    chk("t6_pre_hour", 32'(sw_if.o_hour), 12);
    #2 reset = 1'b0;
    #1;
    m_t = 0; m_ph = 0; m_tick = 1'b0;
    check_all("t6_async");
    cycle("t6_held");
    reset = 1'b1;

    // Random run/clear/reset traffic with occasional deposits near carries.
    for (int i = 0; i < 3000; i++) begin
      if (reset && $urandom_range(0, 99) < 2)
        preload($urandom_range(0, 23), $urandom_range(55, 59),
                $urandom_range(55, 59), $urandom_range(95, 99));
      drive($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 3);
      reset = ($urandom_range(0, 299) != 0);
      cycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
